// File: rtl/io_ctrl_pkg.sv
// Shared definitions for the key/mode controller: ALU mode encoding,
// CPU register addresses and the accepted-press counter width.
package io_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_ADD = 2'b00,
      MODE_SUB = 2'b01,
      MODE_XOR = 2'b10
   } mode_e;

   localparam logic [1:0] ADDR_SW    = 2'd0;
   localparam logic [1:0] ADDR_MODE  = 2'd1;
   localparam logic [1:0] ADDR_FLAGS = 2'd2;
   localparam logic [1:0] ADDR_CNT   = 2'd3;

   localparam int EVT_CNT_W = 16;

endpackage

// File: rtl/key_debouncer.sv
// Single-key conditioner: synchronizer chain, stability down-counter and
// falling-edge press detector. Keys are active-low; reset state is released.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clock,
   input  logic resetn,
   input  logic key_raw,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   db_q, db_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   press_q, press_d;
   logic                   sample;

   assign sample = sync_q[SYNC_STAGES-1];
   assign press  = press_q;

   // cnt_q == 0 means idle; a differing sample loads the count of further
   // differing samples still needed, any agreeing sample abandons the attempt.
   always_comb begin
      sync_d[0] = key_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      db_d  = db_q;
      cnt_d = cnt_q;
      if (sample == db_q) begin
         cnt_d = '0;
      end else if ((DEBOUNCE_CYCLES == 1) || (cnt_q == CNT_ONE)) begin
         db_d  = sample;
         cnt_d = '0;
      end else if (cnt_q == '0) begin
         cnt_d = CNT_LOAD;
      end else begin
         cnt_d = cnt_q - CNT_ONE;
      end
      press_d = db_q & ~db_d;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         sync_q  <= '1;
         db_q    <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

endmodule

// File: rtl/io_key_mode_ctrl.sv
// Push-button ALU mode selector with CPU-readable status registers.
// Optional feature macro: KEY_EVENT_COUNT_EN (accepted-press counter at addr 3).
//
// state    | meaning
// MODE_ADD | datapath adds (reset state, selected by key3)
// MODE_SUB | datapath subtracts (selected by key2)
// MODE_XOR | datapath XORs (selected by key1)
module io_key_mode_ctrl
   import io_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SYNC_STAGES     = 2
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [3:1]  key,
   input  logic [9:0]  sw,
   input  logic        io_rd,
   input  logic [1:0]  io_addr,
   output logic [31:0] io_rdata,
   output logic [1:0]  mode,
   output logic        mode_changed,
   output logic [9:0]  led
);

   logic [3:1]                  press_raw;
   logic [3:1]                  ev;
   logic [SYNC_STAGES-1:0][9:0] sw_sync_q, sw_sync_d;
   logic [9:0]                  sw_s;
   mode_e                       mode_q, mode_d;
   logic                        mode_changed_q, mode_changed_d;
   logic [2:0]                  flags_q, flags_d;
   logic [31:0]                 io_rdata_q, io_rdata_d;
   logic [31:0]                 rd_word;
   logic [31:0]                 cnt_word;

   for (genvar k = 1; k <= 3; k++) begin : g_key
      key_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .SYNC_STAGES    (SYNC_STAGES)
      ) u_deb (
         .clock  (clock),
         .resetn (resetn),
         .key_raw(key[k]),
         .press  (press_raw[k])
      );
   end

   // Priority key3 > key2 > key1; losing events of the same cycle are dropped.
   always_comb begin
      ev = 3'b000;
      if (press_raw[3])      ev = 3'b100;
      else if (press_raw[2]) ev = 3'b010;
      else if (press_raw[1]) ev = 3'b001;
   end

   // Mode next-state; the change pulse is only for an actual mode change.
   always_comb begin
      mode_d = mode_q;
      if (ev[3])      mode_d = MODE_ADD;
      else if (ev[2]) mode_d = MODE_SUB;
      else if (ev[1]) mode_d = MODE_XOR;
      mode_changed_d = (mode_d != mode_q);
   end

   // Switch synchronizer chain.
   always_comb begin
      sw_sync_d[0] = sw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sw_sync_d[i] = sw_sync_q[i-1];
      end
   end

   assign sw_s = sw_sync_q[SYNC_STAGES-1];

`ifdef KEY_EVENT_COUNT_EN
   logic [EVT_CNT_W-1:0] evt_cnt_q, evt_cnt_d;

   // One count per cycle holding any arbitrated press; wraps naturally.
   always_comb evt_cnt_d = (|ev) ? evt_cnt_q + EVT_CNT_W'(1) : evt_cnt_q;

   // Counter register.
   always_ff @(posedge clock) begin
      if (!resetn) evt_cnt_q <= '0;
      else         evt_cnt_q <= evt_cnt_d;
   end

   assign cnt_word = {{(32-EVT_CNT_W){1'b0}}, evt_cnt_q};
`else
   assign cnt_word = '0;
`endif

   // Read mux, sticky-flag update and read-data capture; a new press wins
   // over the clear caused by a read of the flags in the same cycle.
   always_comb begin
      case (io_addr)
         ADDR_SW:    rd_word = {22'b0, sw_s};
         ADDR_MODE:  rd_word = {30'b0, mode_q};
         ADDR_FLAGS: rd_word = {29'b0, flags_q};
         ADDR_CNT:   rd_word = cnt_word;
         default:    rd_word = '0;
      endcase
      flags_d = flags_q;
      if (io_rd && (io_addr == ADDR_FLAGS)) flags_d = 3'b000;
      flags_d    = flags_d | ev;
      io_rdata_d = io_rd ? rd_word : io_rdata_q;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         sw_sync_q      <= '0;
         mode_q         <= MODE_ADD;
         mode_changed_q <= 1'b0;
         flags_q        <= 3'b000;
         io_rdata_q     <= '0;
      end else begin
         sw_sync_q      <= sw_sync_d;
         mode_q         <= mode_d;
         mode_changed_q <= mode_changed_d;
         flags_q        <= flags_d;
         io_rdata_q     <= io_rdata_d;
      end
   end

   assign mode         = mode_q;
   assign mode_changed = mode_changed_q;
   assign io_rdata     = io_rdata_q;
   assign led          = {4'b0000, flags_q,
                          (mode_q == MODE_XOR), (mode_q == MODE_SUB), (mode_q == MODE_ADD)};

endmodule

// File: tb/tb_io_key_mode_ctrl.sv
// Directed bench for io_key_mode_ctrl with DEBOUNCE_CYCLES = 4.
// Build with +define+KEY_EVENT_COUNT_EN to check the press counter at addr 3.
module tb_io_key_mode_ctrl;

   logic        clock = 1'b0;
   logic        resetn;
   logic [3:1]  key;
   logic [9:0]  sw;
   logic        io_rd;
   logic [1:0]  io_addr;
   logic [31:0] io_rdata;
   logic [1:0]  mode;
   logic        mode_changed;
   logic [9:0]  led;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          pulses  = 0;
   int          p0;
   logic [31:0] rd_val;

   always #5 clock = ~clock;

   io_key_mode_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .SYNC_STAGES    (2)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .key         (key),
      .sw          (sw),
      .io_rd       (io_rd),
      .io_addr     (io_addr),
      .io_rdata    (io_rdata),
      .mode        (mode),
      .mode_changed(mode_changed),
      .led         (led)
   );

   always @(negedge clock) begin
      if (mode_changed === 1'b1) pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_read(input logic [1:0] a, output logic [31:0] d);
      io_rd   = 1'b1;
      io_addr = a;
      @(negedge clock);
      io_rd   = 1'b0;
      d       = io_rdata;
   endtask

   task automatic press(input int k);
      logic [3:1] v;
      v    = 3'b111;
      v[k] = 1'b0;
      key  = v;
      cycles(10);
      key  = 3'b111;
      cycles(10);
   endtask

   initial begin
      resetn  = 1'b0;
      key     = 3'b111;
      sw      = 10'h000;
      io_rd   = 1'b0;
      io_addr = 2'd0;
      cycles(3);
      check("reset_mode", 32'(mode), 32'h0);
      check("reset_mc", 32'(mode_changed), 32'h0);
      check("reset_rdata", io_rdata, 32'h0);
      resetn = 1'b1;
      cycles(1);
      check("led_after_reset", 32'(led), 32'h001);

      cycles(20);
      check("idle_pulses", pulses, 0);
      check("idle_mode", 32'(mode), 32'h0);
      check("idle_led", 32'(led), 32'h001);

      key = 3'b101;
      cycles(10);
      key = 3'b111;
      cycles(10);
      check("key2_pulses", pulses, 1);
      check("key2_mode", 32'(mode), 32'h1);
      check("key2_led", 32'(led), 32'h012);
      do_read(2'd1, rd_val);
      check("key2_addr1", rd_val, 32'h1);
      do_read(2'd2, rd_val);
      check("flags_read1", rd_val, 32'h2);
      cycles(3);
      check("rdata_hold", io_rdata, 32'h2);
      do_read(2'd2, rd_val);
      check("flags_read2", rd_val, 32'h0);
      check("led_flags_cleared", 32'(led), 32'h002);

      key = 3'b101;
      cycles(2);
      key = 3'b111;
      cycles(12);
      check("glitch_pulses", pulses, 1);
      check("glitch_mode", 32'(mode), 32'h1);
      do_read(2'd2, rd_val);
      check("glitch_flags", rd_val, 32'h0);

      key = 3'b010;
      cycles(10);
      key = 3'b111;
      cycles(10);
      check("k31_pulses", pulses, 2);
      check("k31_mode", 32'(mode), 32'h0);
      check("k31_led", 32'(led), 32'h021);
      do_read(2'd2, rd_val);
      check("k31_flags", rd_val, 32'h4);

      sw = 10'b1010101010;
      cycles(3);
      do_read(2'd0, rd_val);
      check("sw_read1", rd_val, 32'h2AA);
      sw = ~10'b1010101010;
      cycles(3);
      check("sw_hold", io_rdata, 32'h2AA);
      do_read(2'd0, rd_val);
      check("sw_read2", rd_val, 32'h155);

      press(1);
      check("key1_mode", 32'(mode), 32'h2);
      check("key1_pulses", pulses, 3);
      key = 3'b011;
      cycles(4);
      resetn  = 1'b0;
      io_rd   = 1'b1;
      io_addr = 2'd0;
      key     = 3'b111;
      cycles(2);
      check("rst_mid_rdata", io_rdata, 32'h0);
      check("rst_mid_mode", 32'(mode), 32'h0);
      io_rd  = 1'b0;
      resetn = 1'b1;
      p0     = pulses;
      cycles(20);
      check("rst_mid_pulses", pulses, p0);
      check("rst_mid_led", 32'(led), 32'h001);
      do_read(2'd2, rd_val);
      check("rst_mid_flags", rd_val, 32'h0);

      press(2);
      check("seq_k2_mode", 32'(mode), 32'h1);
      press(1);
      check("seq_k1_mode", 32'(mode), 32'h2);
      press(3);
      check("seq_k3_mode", 32'(mode), 32'h0);
      check("seq_pulses", pulses, p0 + 3);
      do_read(2'd3, rd_val);
`ifdef KEY_EVENT_COUNT_EN
      check("cnt_after_3", rd_val, 32'h3);
`else
      check("addr3_zero", rd_val, 32'h0);
`endif
      press(3);
      check("same_mode_pulses", pulses, p0 + 3);
      check("same_mode_mode", 32'(mode), 32'h0);
      do_read(2'd3, rd_val);
`ifdef KEY_EVENT_COUNT_EN
      check("cnt_after_4", rd_val, 32'h4);
`else
      check("addr3_zero2", rd_val, 32'h0);
`endif
      do_read(2'd2, rd_val);
      check("seq_flags", rd_val, 32'h7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/io_key_mode_ctrl.md
IO_KEY_MODE_CTRL -- requirements
Module: io_key_mode_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a key level
  SYNC_STAGES, 2, synchronizer flop depth on key and sw inputs
REQ-002 Ports SHALL be, one per line:
  clock  in  1  single system clock; all state on rising edge
  resetn  in  1  synchronous, active-low reset
  key  in  3 [3:1]  raw push-buttons, active-low
  sw  in  10  raw slide switches
  io_rd  in  1  CPU read strobe, one cycle
  io_addr  in  2  register select
  io_rdata  out  32  read data
  mode  out  2  ALU mode to datapath: 00 ADD, 01 SUB, 10 XOR
  mode_changed  out  1  one-cycle pulse on mode update
  led  out  10  status LEDs

Function
REQ-003 key and sw SHALL pass through SYNC_STAGES flops before any use.
REQ-004 Each key SHALL be debounced independently: a new level is accepted only after DEBOUNCE_CYCLES consecutive identical synchronized samples; the counter restarts on any mismatch.
REQ-005 A press event SHALL be one cycle, asserted when a debounced key goes 1->0; release generates no event.
REQ-006 Mode FSM states SHALL be ADD, SUB, XOR; key1 press -> XOR, key2 press -> SUB, key3 press -> ADD, from any state.
REQ-007 Simultaneous press events SHALL resolve key3 > key2 > key1; lower-priority events in that cycle are discarded.
REQ-008 mode SHALL update the cycle after the press event; mode_changed SHALL pulse in that same cycle only if the new mode differs from the old one.
REQ-009 Register map: addr 0 = {22'b0, sw_sync}; addr 1 = {30'b0, mode}; addr 2 = {29'b0, sticky press flags [2:0] for keys 3..1}; addr 3 per REQ-016.
REQ-010 io_rdata SHALL be registered, valid exactly one cycle after io_rd, and hold its value until the next io_rd.
REQ-011 Reading addr 2 SHALL clear the sticky flags returned; a press event in the same cycle as the clearing read SHALL leave its flag set.
REQ-012 led[2:0] SHALL be one-hot mode (bit0 ADD, bit1 SUB, bit2 XOR); led[5:3] = sticky flags; led[9:6] = 0.

Reset
REQ-013 With resetn low at a rising edge: mode = ADD, mode_changed = 0, io_rdata = 0, sticky flags = 0, debounced keys = 1 (released), debounce counters = 0, synchronizers = released/0.
REQ-014 Reset mid-debounce or mid-read SHALL abandon that operation; no press event or mode_changed pulse SHALL result from reset deassertion.
REQ-015 led SHALL read 10'b0000000001 in the cycle after reset.

Configuration
REQ-016 Macro KEY_EVENT_COUNT_EN: when defined, a 16-bit accepted-press counter (increments once per cycle containing any press event, after REQ-007 arbitration) SHALL be readable at addr 3 as {16'b0, count}, wrapping 0xFFFF -> 0x0000, reset to 0; when undefined, addr 3 SHALL read 0 and no counter logic is built.

Structure
REQ-017 Shared package io_ctrl_pkg SHALL hold the mode encoding type (ADD/SUB/XOR), register address constants, and counter width.
REQ-018 Sub-module key_debouncer (synchronizer + counter + edge detect, parameterized by DEBOUNCE_CYCLES) SHALL be instantiated once per key.

Verification
REQ-019 Bench SHALL cover, with DEBOUNCE_CYCLES = 4:
  Reset, then idle 20 cycles -> mode = 00, led = 10'h001, mode_changed never high.
  key = 3'b101 held 10 cycles -> exactly one mode_changed pulse, mode = 01; addr 2 read -> 32'h2, second read -> 32'h0.
  key2 low for 2 cycles only (glitch) -> no event, mode unchanged, flags 0.
  key = 3'b010 (key3 + key1 together) from SUB -> mode = 00 (ADD), one pulse; addr 2 reads 32'h4.
  sw = 10'b1010101010 then inverted -> addr 0 read returns 32'h2AA, then 32'h155 after sync latency.
  With KEY_EVENT_COUNT_EN: 3 presses (key2, key1, key3) -> addr 3 reads 32'h3; key3 press from ADD -> count increments, no mode_changed.
